// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main controller for a multicycle MIPS datapath (one ALU, one unified memory).
// A Moore FSM steps each instruction through fetch, decode, execute, memory and
// writeback. It drives the datapath mux selects and write enables, and issues
// 3-bit ALU control codes.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   op        in   [5:0] instr[31:26] from the instruction register
//   funct     in   [5:0] instr[5:0] from the instruction register
//   zero      in   ALU zero flag (used only while resolving a beq)
//   aluop     out  [2:0] 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   alusrca   out  0 = PC, 1 = regA
//   alusrcb   out  [1:0] 00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc     out  [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   pcen      out  PC write enable
//   iord      out  memory address: 0 = PC, 1 = ALUOut
//   memwrite  out  memory write enable
//   irwrite   out  instruction register write enable
//   regdst    out  write register: 0 = rt, 1 = rd
//   memtoreg  out  write data: 0 = ALUOut, 1 = memory data
//   regwrite  out  register file write enable
//   done      out  high in the last cycle of each instruction
//   illegal   out  unsupported op/funct seen in DECODE
//   state     out  [STATE_W-1:0] current state, for debug
//
// Handshake: the controller has no valid/ready channels. Each output is
// meaningful in the cycle it is asserted. done marks the final cycle of an
// instruction, and the next cycle is always FETCH.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [2:0]         aluop,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_RTYPEEX = STATE_W'(6),
    S_ALUWB   = STATE_W'(7),
    S_BEQEX   = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JEX     = STATE_W'(11)
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e     state_q;
  state_e     state_d;
  state_e     out_st;      // state used for output decode
  logic       rt_ok;       // funct is a supported R-type operation
  logic [2:0] rt_aluop;
  state_e     dec_next;    // successor of DECODE for the current op
  logic       dec_illegal;

  // R-type funct to ALU control.
  always_comb begin
    rt_ok    = 1'b1;
    rt_aluop = ALU_ADD;
    case (funct)
      6'b100000: rt_aluop = ALU_ADD;
      6'b100010: rt_aluop = ALU_SUB;
      6'b100100: rt_aluop = ALU_AND;
      6'b100101: rt_aluop = ALU_OR;
      6'b101010: rt_aluop = ALU_SLT;
      default:   rt_ok    = 1'b0;
    endcase
  end

  // Opcode dispatch out of DECODE. Anything unsupported returns to FETCH
  // and is flagged illegal in that same DECODE cycle.
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_RTYPE: begin
        if (rt_ok) dec_next    = S_RTYPEEX;
        else       dec_illegal = 1'b1;
      end
      OP_BEQ:  dec_next    = S_BEQEX;
      OP_ADDI: dec_next    = S_ADDIEX;
      OP_J:    dec_next    = S_JEX;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state logic. Unused codes 12..15 fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = dec_next;
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // While reset is held, decode as FETCH, even if the register still holds a
  // mid-instruction state. The four write enables are masked below so no
  // architectural state changes during reset.
  assign out_st = reset ? S_FETCH : state_q;

  always_comb begin
    aluop    = ALU_ADD;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (out_st)
      S_FETCH: begin
        alusrcb = 2'b01;   // PC + 4
        irwrite = 1'b1;
        pcen    = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;   // speculative branch target into ALUOut
        illegal = dec_illegal;
        done    = dec_illegal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        done     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = rt_aluop;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;   // branch target computed in DECODE
        pcen    = zero;
        done    = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Bench for the multicycle MIPS controller. Each instruction is expanded into
// its expected per-cycle state path and output set. Expected entries are queued
// and checked against the DUT at every falling edge. Inputs that the
// controller must ignore are randomised. Directed cases fix the reset
// behaviour and the cycles-per-instruction figures.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       done;
    logic       illegal;
  } obs_t;

  localparam int W = $bits(obs_t);

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       done, illegal;
  logic [3:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .aluop    (aluop),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .pcen     (pcen),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .done     (done),
    .illegal  (illegal),
    .state    (state)
  );

  obs_t dut_obs;
  assign dut_obs = {state, aluop, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
                    irwrite, regdst, memtoreg, regwrite, done, illegal};

  // ---------------- reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int run_len  = 0;
  int last_len = 0;

  // Index of a supported R-type funct, or -1.
  function automatic int funct_idx(input logic [5:0] fn);
    logic [5:0] fns [5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < 5; i++) if (fns[i] == fn) return i;
    return -1;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] alus [5];
    int i;
    alus = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    i = funct_idx(fn);
    return (i < 0) ? 3'b010 : alus[i];
  endfunction

  // Outputs expected in a given state, from the per-state table.
  function automatic obs_t model_obs(input int st, input logic [5:0] fn,
                                     input logic z, input logic ill);
    obs_t o;
    o = '0;
    o.aluop = 3'b010;
    o.st = 4'(st);
    case (st)
      0:  begin o.srcb = 2'b01; o.irwrite = 1'b1; o.pcen = 1'b1; end
      1:  begin o.srcb = 2'b11; o.illegal = ill; o.done = ill; end
      2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; o.done = 1'b1; end
      5:  begin o.iord = 1'b1; o.memwrite = 1'b1; o.done = 1'b1; end
      6:  begin o.srca = 1'b1; o.aluop = funct_alu(fn); end
      7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; o.done = 1'b1; end
      8:  begin o.srca = 1'b1; o.aluop = 3'b110; o.pcsrc = 2'b01; o.pcen = z; o.done = 1'b1; end
      9:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      10: begin o.regwrite = 1'b1; o.done = 1'b1; end
      11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; o.done = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // During reset: FETCH decode with the write enables masked, state unchanged.
  function automatic obs_t reset_obs(input int st);
    obs_t o;
    o = model_obs(0, 6'd0, 1'b0, 1'b0);
    o.pcen = 1'b0;
    o.irwrite = 1'b0;
    o.st = 4'(st);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d aluop=%b a=%b b=%b pcsrc=%b pcen=%b iord=%b mw=%b irw=%b rd=%b m2r=%b rw=%b done=%b ill=%b",
                     o.st, o.aluop, o.srca, o.srcb, o.pcsrc, o.pcen, o.iord, o.memwrite,
                     o.irwrite, o.regdst, o.memtoreg, o.regwrite, o.done, o.illegal);
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (dut_obs !== e) begin
        n_err++;
        $display("FAIL cycle_obs t=%0t got {%s} want {%s}", $time, fmt(dut_obs), fmt(e));
      end
      n_vec++;
      if (memwrite === 1'b1 && regwrite === 1'b1) begin
        n_err++;
        $display("FAIL mw_rw_excl t=%0t got mw=1 rw=1 want not both", $time);
      end
      if (reset) run_len = 0;
      else begin
        run_len++;
        if (done === 1'b1) begin
          last_len = run_len;
          run_len = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_reset(input int st);
    reset = 1'b1;
    op    = 6'($urandom);
    funct = 6'($urandom);
    zero  = 1'($urandom);
    exp_q.push_back(reset_obs(st));
    @(posedge clk); #1;
  endtask

  // One instruction from FETCH. abort_at >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] fn_v,
                           input logic z, input int abort_at);
    int p [5];
    int n;
    logic ill, need_op, need_fn;
    obs_t e;
    ill = 1'b0;
    p = '{0, 1, 0, 0, 0};
    n = 2;
    if (op_v == 6'b100011)                             begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
    else if (op_v == 6'b101011)                        begin p[2] = 2; p[3] = 5; n = 4; end
    else if (op_v == 6'b000000 && funct_idx(fn_v) >= 0) begin p[2] = 6; p[3] = 7; n = 4; end
    else if (op_v == 6'b000100)                        begin p[2] = 8; n = 3; end
    else if (op_v == 6'b001000)                        begin p[2] = 9; p[3] = 10; n = 4; end
    else if (op_v == 6'b000010)                        begin p[2] = 11; n = 3; end
    else ill = 1'b1;
    for (int k = 0; k < n; k++) begin
      need_op = (k == 1) || (k == 2 && (p[2] == 2 || p[2] == 6));
      need_fn = (k == 1) || (k == 2 && p[2] == 6);
      op    = need_op ? op_v : 6'($urandom);
      funct = need_fn ? fn_v : 6'($urandom);
      zero  = (p[k] == 8) ? z : 1'($urandom);
      if (k == abort_at) begin
        reset = 1'b1;
        e = reset_obs(p[k]);
      end else begin
        reset = 1'b0;
        e = model_obs(p[k], fn_v, z, ill && (k == 1));
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (k == abort_at) break;
    end
    reset = 1'b0;
  endtask

  task automatic pin_cpi(input string name, input int want);
    n_vec++;
    if (last_len != want) begin
      n_err++;
      $display("FAIL cpi_%s got %0d cycles want %0d", name, last_len, want);
    end
  endtask

  task automatic pin_bit(input string name, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] rfn [5];
    int kind, ab;
    logic [5:0] o_r, f_r;
    rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    @(posedge clk); #1;
    repeat (3) drive_reset(0);

    // First post-reset cycle, pinned with literals.
    reset = 1'b0; op = 6'b100011; funct = '0;
    #1;
    pin_bit("post_rst_state",   state,            4'd0);
    pin_bit("post_rst_irwrite", {3'b0, irwrite},  4'd1);
    pin_bit("post_rst_pcen",    {3'b0, pcen},     4'd1);
    pin_bit("post_rst_alusrcb", {2'b0, alusrcb},  4'b0001);
    pin_bit("post_rst_aluop",   {1'b0, aluop},    4'b0010);

    run_instr(6'b100011, 6'($urandom), 1'b0, -1); pin_cpi("lw", 5);
    for (int i = 0; i < 5; i++) begin
      run_instr(6'b000000, rfn[i], 1'b0, -1); pin_cpi("rtype", 4);
    end
    run_instr(6'b000100, 6'($urandom), 1'b1, -1); pin_cpi("beq_taken", 3);
    run_instr(6'b000100, 6'($urandom), 1'b0, -1); pin_cpi("beq_not", 3);
    run_instr(6'b101011, 6'($urandom), 1'b0, -1); pin_cpi("sw", 4);
    run_instr(6'b000010, 6'($urandom), 1'b0, -1); pin_cpi("j", 3);
    run_instr(6'b001000, 6'($urandom), 1'b0, -1); pin_cpi("addi", 4);
    run_instr(6'b111111, 6'($urandom), 1'b0, -1); pin_cpi("illegal_op", 2);
    run_instr(6'b000000, 6'b000000, 1'b0, -1);    pin_cpi("illegal_funct", 2);
    // Reset while in MEMWR: no memory write, back to FETCH.
    run_instr(6'b101011, 6'($urandom), 1'b0, 3);
    run_instr(6'b100011, 6'($urandom), 1'b0, -1); pin_cpi("lw_after_abort", 5);

    repeat (400) begin
      kind = $urandom_range(0, 8);
      f_r  = rfn[$urandom_range(0, 4)];
      case (kind)
        0: o_r = 6'b100011;
        1: o_r = 6'b101011;
        2, 3: o_r = 6'b000000;
        4: o_r = 6'b000100;
        5: o_r = 6'b001000;
        6: o_r = 6'b000010;
        7: o_r = 6'($urandom);
        default: begin o_r = 6'b000000; f_r = 6'($urandom); end
      endcase
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(o_r, f_r, 1'($urandom), ab);
    end

    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main controller. It is the initiator side of the 3-bit ALU-control interface: it drives aluop codes into the ALU and consumes the ALU zero flag.
- A Moore FSM sequences fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables.
- It sits between the instruction register (op/funct) and the shared multicycle datapath: one ALU, one unified memory.

Parameters:
- STATE_W, 4, state register width (12 states used).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag
- aluop  output  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- alusrca  output  1  0 = PC, 1 = regA
- alusrcb  output  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- pcen  output  1  PC write enable
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register write enable
- regdst  output  1  write register: 0 = rt, 1 = rd
- memtoreg  output  1  write data: 0 = ALUOut, 1 = memory data
- regwrite  output  1  register file write enable
- done  output  1  high in the last cycle of each instruction
- illegal  output  1  unsupported op/funct detected in DECODE
- state  output  STATE_W  current state, for debug

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 go to FETCH on the next edge.
- Reset: at a clk edge with reset=1, state becomes FETCH.
- While reset=1, pcen, irwrite, memwrite and regwrite are forced to 0. All other outputs follow the FETCH decode.
- Outputs are combinational from the state register only. The exceptions are aluop in RTYPEEX (uses funct), pcen in BEQEX (uses zero), and illegal (uses op/funct).
- Unlisted outputs in each state are 0; aluop defaults to 010.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=010, pcsrc=00, irwrite=1, pcen=1. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=010. Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 with a supported funct → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - anything else → FETCH, with illegal=1 and done=1 in this cycle.
- Supported R-type functs: 100000 add→010, 100010 sub→110, 100100 and→000, 100101 or→001, 101010 slt→111.
- MEMADR: alusrca=1, alusrcb=10, aluop=010. Next state is MEMRD if op=100011, otherwise MEMWR.
- MEMRD: iord=1. Next state is MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, done=1. Next state is FETCH.
- MEMWR: iord=1, memwrite=1, done=1. Next state is FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop from the funct map. Next state is ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, done=1. Next state is FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=110, pcsrc=01, pcen=zero, done=1. Next state is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=010. Next state is ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, done=1. Next state is FETCH.
- JEX: pcsrc=10, pcen=1, done=1. Next state is FETCH.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- op/funct are sampled only in DECODE, MEMADR and RTYPEEX; values in other states are ignored.
- zero is used only in BEQEX.
- Reset asserted mid-instruction: return to FETCH on the next edge; no memwrite or regwrite issued while reset=1.
- Invariants:
  - done is high exactly once per instruction.
  - memwrite and regwrite are never high together.
  - pcen is high at most twice per instruction (FETCH plus one of BEQEX/JEX).

Test Plan:
- Reset held 3 cycles, then released → state=0 and pcen=irwrite=0 while reset=1. First post-reset cycle: irwrite=1, pcen=1, alusrcb=01, aluop=010.
- lw (op=100011) → states 0,1,2,3,4. regwrite=1 and memtoreg=1 only in state 4; done pulses once; 5 cycles total.
- R-type sweep with funct 100000/100010/100100/100101/101010 → aluop in state 6 is 010/110/000/001/111. regdst=1 and regwrite=1 in state 7.
- beq with zero=1, then beq with zero=0 → in state 8 aluop=110 and pcsrc=01. pcen=1 in the first case, 0 in the second. 3 cycles each.
- sw → states 0,1,2,5, with memwrite=1 and iord=1 only in state 5. j → state 11 with pcsrc=10 and pcen=1.
- op=111111, and op=000000 with funct=000000 → illegal=1 and done=1 in DECODE, then FETCH. Separately, reset asserted in MEMWR → memwrite=0, state=0 on the next edge.
